// File: rtl/led_cube_pkg.sv
// Shared types, geometry constants and the frame-buffer address packing for the LED cube scan.
package led_cube_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      LOAD  = 2'd2,
      SHOW  = 2'd3
   } scan_state_t;

   localparam int unsigned N_LAYERS        = 8;
   localparam int unsigned BYTES_PER_LAYER = 8;

   function automatic logic [5:0] frame_addr_pack(input logic [2:0] layer_idx,
                                                  input logic [2:0] byte_idx);
      return {layer_idx, byte_idx};
   endfunction

endpackage

// File: rtl/led_cube_dwell_timer.sv
// Loadable 16-bit phase timer: times one BLANK or SHOW period and the on-window inside it.
module led_cube_dwell_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_count,
   input  logic [15:0] load_on,
   output logic        on_active,
   output logic        expired
);

   logic [15:0] count_reg;
   logic [15:0] on_left_reg;
   logic [15:0] on_sat;

   // On-time can never exceed the period it sits in.
   assign on_sat = (load_on > load_count) ? load_count : load_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg   <= '0;
         on_left_reg <= '0;
      end else if (load) begin
         count_reg   <= load_count;
         on_left_reg <= on_sat;
      end else begin
         if (count_reg != '0) begin
            count_reg <= count_reg - 16'd1;
         end
         if (on_left_reg != '0) begin
            on_left_reg <= on_left_reg - 16'd1;
         end
      end
   end

   // expired flags the last cycle of the running period; on_active looks one cycle ahead
   // so the owner can register its drive outputs.
   assign expired   = (count_reg == 16'd1);
   assign on_active = load ? (on_sat != '0) : (on_left_reg > 16'd1);

endmodule

// File: rtl/led_cube_layer_scan.sv
// Layer-multiplex scan controller: blank, load eight column bytes, then show one layer with PWM dwell.
module led_cube_layer_scan
   import led_cube_pkg::*;
#(
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned DWELL_CYCLES = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] on_cycles,
   input  logic [7:0]  data_to_latch,
   output logic [5:0]  frame_addr,
   output logic [7:0]  latch_data,
   output logic [7:0]  latch_sel,
   output logic [7:0]  layer_en,
   output logic [2:0]  cur_layer,
   output logic        frame_done
);

   scan_state_t state_reg, state_next;
   logic [2:0]  layer_reg, layer_next;
   logic [2:0]  byte_reg, byte_next;
   logic        phase_reg, phase_next;

   logic        timer_load;
   logic [15:0] timer_count;
   logic [15:0] timer_on;
   logic        timer_on_active;
   logic        timer_expired;

   logic [5:0]  frame_addr_next;
   logic [7:0]  latch_data_next;
   logic [7:0]  latch_sel_next;
   logic [7:0]  layer_en_next;
   logic        frame_done_next;

   logic [N_LAYERS-1:0]        layer_dec;
   logic [BYTES_PER_LAYER-1:0] byte_dec;

   genvar gi;
   generate
      for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer_dec
         assign layer_dec[gi] = (layer_next == 3'(gi));
      end
      for (gi = 0; gi < BYTES_PER_LAYER; gi++) begin : g_byte_dec
         assign byte_dec[gi] = (byte_next == 3'(gi));
      end
   endgenerate

   led_cube_dwell_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_count (timer_count),
      .load_on    (timer_on),
      .on_active  (timer_on_active),
      .expired    (timer_expired)
   );

   always_comb begin
      state_next      = state_reg;
      layer_next      = layer_reg;
      byte_next       = byte_reg;
      phase_next      = phase_reg;
      timer_load      = 1'b0;
      timer_count     = 16'(BLANK_CYCLES);
      timer_on        = '0;
      frame_done_next = 1'b0;

      if (!enable) begin
         state_next = IDLE;
         layer_next = '0;
         byte_next  = '0;
         phase_next = 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               state_next = BLANK;
               timer_load = 1'b1;
            end
            BLANK: begin
               if (timer_expired) begin
                  state_next = LOAD;
                  byte_next  = '0;
                  phase_next = 1'b0;
               end
            end
            LOAD: begin
               if (!phase_reg) begin
                  phase_next = 1'b1;
               end else begin
                  phase_next = 1'b0;
                  byte_next  = byte_reg + 3'd1;
                  if (byte_reg == 3'(BYTES_PER_LAYER - 1)) begin
                     state_next  = SHOW;
                     timer_load  = 1'b1;
                     timer_count = 16'(DWELL_CYCLES);
                     timer_on    = on_cycles;
                  end
               end
            end
            SHOW: begin
               if (timer_expired) begin
                  state_next = BLANK;
                  timer_load = 1'b1;
                  if (layer_reg == 3'(N_LAYERS - 1)) begin
                     layer_next      = '0;
                     frame_done_next = 1'b1;
                  end else begin
                     layer_next = layer_reg + 3'd1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end

      // Drive outputs are registered from the state of the coming cycle.
      frame_addr_next = frame_addr_pack(layer_next, byte_next);
      latch_data_next = latch_data;
      if (state_reg == LOAD && !phase_reg) begin
         latch_data_next = data_to_latch;
      end
      if (state_next == IDLE) begin
         latch_data_next = '0;
      end
      latch_sel_next = (state_next == LOAD && phase_next) ? byte_dec : '0;
      layer_en_next  = (state_next == SHOW && timer_on_active) ? layer_dec : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         layer_reg  <= '0;
         byte_reg   <= '0;
         phase_reg  <= 1'b0;
         frame_addr <= '0;
         latch_data <= '0;
         latch_sel  <= '0;
         layer_en   <= '0;
         frame_done <= 1'b0;
      end else begin
         state_reg  <= state_next;
         layer_reg  <= layer_next;
         byte_reg   <= byte_next;
         phase_reg  <= phase_next;
         frame_addr <= frame_addr_next;
         latch_data <= latch_data_next;
         latch_sel  <= latch_sel_next;
         layer_en   <= layer_en_next;
         frame_done <= frame_done_next;
      end
   end

   assign cur_layer = layer_reg;

endmodule
